// File: rtl/decoder3_8_pkg.sv
// Shared widths and the 3-to-8 one-hot decode function for decoder3_8.
package decoder3_8_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  function automatic logic [OUT_W-1:0] dec3to8(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] code;
    code = '0;
    code[sel] = 1'b1;
    return code;
  endfunction

endpackage

// File: rtl/decoder3_8.sv
// Registered 3-to-8 decoder: {in1,in2,in3} selects one output line one clock later.
// Polarity is applied before the register so the flop holds the final line levels.
module decoder3_8
  import decoder3_8_pkg::*;
#(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in1,
  input  logic             in2,
  input  logic             in3,
  output logic [OUT_W-1:0] out
);

  // Idle pattern: no line selected in the configured polarity.
  localparam logic [OUT_W-1:0] IDLE = ACTIVE_HIGH ? {OUT_W{1'b0}} : {OUT_W{1'b1}};

  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] out_next;

  assign sel    = {in1, in2, in3};
  assign onehot = dec3to8(sel);

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pol
    assign out_next[gi] = onehot[gi] ^ !ACTIVE_HIGH;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      out <= IDLE;
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: tb/tb_decoder3_8.sv
// Scoreboard bench for decoder3_8: both polarities driven from the same select inputs.
module tb_decoder3_8;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       in1, in2, in3;
  logic [7:0] out;
  logic [7:0] out_n;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  decoder3_8 #(.ACTIVE_HIGH(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in1(in1), .in2(in2), .in3(in3), .out(out)
  );

  decoder3_8 #(.ACTIVE_HIGH(1'b0)) dut_n (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in1(in1), .in2(in2), .in3(in3), .out(out_n)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] s);
    logic [7:0] one;
    one = 8'h01;
    return one << s;
  endfunction

  // Drive at the falling edge, compare just after the following rising edge.
  task automatic cycle(input logic [2:0] s, input string tag);
    logic [7:0] expv;
    @(negedge sys_clk);
    {in1, in2, in3} = s;
    exp_q.push_back(model(s));
    @(posedge sys_clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_qempty"}, 8'h01, 8'h00);
    end else begin
      expv = exp_q.pop_front();
      check_eq(tag, out, expv);
      check_eq({tag, "_n"}, out_n, ~expv);
      check_eq({tag, "_pop"}, 8'($countones(out)), 8'd1);
    end
    $display("t=%0t in1=%b in2=%b in3=%b out=%h out_n=%h", $time, in1, in2, in3, out, out_n);
  endtask

  initial begin
    logic [7:0] expv;
    sys_rst = 1'b1;
    {in1, in2, in3} = 3'b101;
    #1;
    check_eq("rst_async", out, 8'h00);
    check_eq("rst_async_n", out_n, 8'hFF);
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      check_eq("rst_hold", out, 8'h00);
      check_eq("rst_hold_n", out_n, 8'hFF);
    end

    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int s = 0; s < 8; s++) cycle(3'(s), $sformatf("sweep%0d", s));

    // Latency: change just after an edge; output must hold until the next edge.
    {in1, in2, in3} = 3'b110;
    exp_q.push_back(model(3'b110));
    @(negedge sys_clk);
    check_eq("lat_hold", out, 8'h80);
    @(posedge sys_clk);
    #1;
    expv = exp_q.pop_front();
    check_eq("lat_update", out, expv);
    check_eq("lat_update_const", out, 8'h40);

    cycle(3'b010, "pol_010");
    check_eq("pol_010_n_const", out_n, 8'b1111_1011);

    cycle(3'b111, "pre_rst");
    #3;
    sys_rst = 1'b1;
    exp_q.delete();
    #1;
    check_eq("mid_rst", out, 8'h00);
    check_eq("mid_rst_n", out_n, 8'hFF);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    {in1, in2, in3} = 3'b011;
    exp_q.push_back(model(3'b011));
    @(posedge sys_clk);
    #1;
    expv = exp_q.pop_front();
    check_eq("rst_release", out, expv);
    check_eq("rst_release_const", out, 8'h08);

    for (int i = 0; i < 1000; i++) cycle(3'($urandom_range(0, 7)), $sformatf("rand%0d", i));

    check_eq("q_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
